pipeline_run_controller: RTL and testbench

- Sequences the five-stage MIPS pipeline by generating its global enable (en_pipeline).
- Supports continuous-run, single-step and abort commands, issued by the debug unit after program load.
- Detects the HALT instruction at fetch, drains the in-flight instructions through writeback, then parks and reports the halt PC and the executed cycle count, so the debug unit can dump registers and memory.

---
 rtl/pipeline_run_controller_if.sv | 21 ++
 rtl/pipeline_run_controller.sv | 165 ++++++++++++++++
 tb/tb_pipeline_run_controller.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_run_controller_if.sv
// Command handshake between the debug unit and the pipeline run controller.
//   cmd_valid : command strobe from the debug unit
//   cmd       : command code (00 none, 01 run, 10 step, 11 abort)
//   cmd_ready : controller can accept a command this cycle
interface pipeline_run_controller_if;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic       cmd_ready;

    modport master (
        output cmd_valid,
        output cmd,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd,
        output cmd_ready
    );
endinterface

// File: rtl/pipeline_run_controller.sv
// Generates the global enable of the five-stage MIPS pipeline. Supports
// continuous run, single step and abort; on a HALT fetch it drains the older
// in-flight instructions, then parks and reports the halt PC and the number
// of enabled cycles.
//   clock, reset        : system clock, synchronous active-high reset
//   cmd_if (slave)      : command handshake (cmd_valid/cmd in, cmd_ready out)
//   instruction_fetch_i : instruction presented by fetch
//   pc_fetch_i          : PC of that instruction
//   en_pipeline_o       : global pipeline enable
//   running_o           : high while the pipeline is enabled
//   step_done_o         : one-cycle pulse when a step completes without HALT
//   halted_o            : high once parked after a HALT
//   halt_pc_o           : PC at which HALT was fetched
//   cycle_count_o       : saturating count of enabled cycles
module pipeline_run_controller #(
    parameter int unsigned        NB_DATA      = 32,
    parameter int unsigned        NB_PC        = 7,
    parameter int unsigned        NB_CYCLES    = 32,
    parameter int unsigned        DRAIN_CYCLES = 4,
    parameter logic [NB_DATA-1:0] HALT_INSTR   = NB_DATA'(32'hFFFF_FFFF)
) (
    input  logic                 clock,
    input  logic                 reset,
    pipeline_run_controller_if.slave cmd_if,
    input  logic [NB_DATA-1:0]   instruction_fetch_i,
    input  logic [NB_PC-1:0]     pc_fetch_i,
    output logic                 en_pipeline_o,
    output logic                 running_o,
    output logic                 step_done_o,
    output logic                 halted_o,
    output logic [NB_PC-1:0]     halt_pc_o,
    output logic [NB_CYCLES-1:0] cycle_count_o
);

    localparam int unsigned NB_DRAIN = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    localparam logic [1:0] CMD_RUN   = 2'b01;
    localparam logic [1:0] CMD_STEP  = 2'b10;
    localparam logic [1:0] CMD_ABORT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_STEP,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e                state_q;
    logic                  en_q;
    logic                  running_q;
    logic                  step_done_q;
    logic                  halted_q;
    logic [NB_PC-1:0]      halt_pc_q;
    logic [NB_CYCLES-1:0]  cycle_count_q;
    logic [NB_CYCLES-1:0]  cycle_count_d;
    logic [NB_DRAIN-1:0]   drain_q;
    logic                  cmd_acc;
    logic                  halt_hit;

    // Ready is decoded straight from the state so a command is never lost.
    assign cmd_if.cmd_ready = (state_q == S_IDLE) || (state_q == S_RUN) || (state_q == S_DONE);
    assign cmd_acc          = cmd_if.cmd_valid && cmd_if.cmd_ready;
    assign halt_hit         = en_q && (instruction_fetch_i == HALT_INSTR);

    // Saturating count of enabled cycles.
    always_comb begin
        cycle_count_d = cycle_count_q;
        if (en_q && (cycle_count_q != '1)) begin
            cycle_count_d = cycle_count_q + NB_CYCLES'(1);
        end
    end

    // Run/step/halt sequencer with registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            en_q          <= 1'b0;
            running_q     <= 1'b0;
            step_done_q   <= 1'b0;
            halted_q      <= 1'b0;
            halt_pc_q     <= '0;
            cycle_count_q <= '0;
            drain_q       <= '0;
        end else begin
            step_done_q   <= 1'b0;
            cycle_count_q <= cycle_count_d;
            case (state_q)
                S_IDLE: begin
                    if (cmd_acc) begin
                        if (cmd_if.cmd == CMD_RUN) begin
                            state_q   <= S_RUN;
                            en_q      <= 1'b1;
                            running_q <= 1'b1;
                        end else if (cmd_if.cmd == CMD_STEP) begin
                            state_q   <= S_STEP;
                            en_q      <= 1'b1;
                            running_q <= 1'b1;
                        end else begin
                            // Explicit abort or none while idle restarts the count.
                            cycle_count_q <= '0;
                        end
                    end
                end
                S_RUN, S_STEP: begin
                    if (halt_hit) begin
                        // HALT outranks both a coincident abort and step completion.
                        halt_pc_q <= pc_fetch_i;
                        drain_q   <= NB_DRAIN'(DRAIN_CYCLES);
                        if (DRAIN_CYCLES == 0) begin
                            state_q   <= S_DONE;
                            en_q      <= 1'b0;
                            running_q <= 1'b0;
                            halted_q  <= 1'b1;
                        end else begin
                            state_q <= S_DRAIN;
                        end
                    end else if (state_q == S_STEP) begin
                        state_q     <= S_IDLE;
                        en_q        <= 1'b0;
                        running_q   <= 1'b0;
                        step_done_q <= 1'b1;
                    end else if (cmd_acc && (cmd_if.cmd == CMD_ABORT)) begin
                        state_q   <= S_IDLE;
                        en_q      <= 1'b0;
                        running_q <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    // Last drain cycle parks the pipeline.
                    if (drain_q <= NB_DRAIN'(1)) begin
                        state_q   <= S_DONE;
                        en_q      <= 1'b0;
                        running_q <= 1'b0;
                        halted_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q - NB_DRAIN'(1);
                    end
                end
                S_DONE: begin
                    if (cmd_acc && (cmd_if.cmd == CMD_ABORT)) begin
                        state_q       <= S_IDLE;
                        halted_q      <= 1'b0;
                        halt_pc_q     <= '0;
                        cycle_count_q <= '0;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    en_q      <= 1'b0;
                    running_q <= 1'b0;
                    halted_q  <= 1'b0;
                end
            endcase
        end
    end

    assign en_pipeline_o = en_q;
    assign running_o     = running_q;
    assign step_done_o   = step_done_q;
    assign halted_o      = halted_q;
    assign halt_pc_o     = halt_pc_q;
    assign cycle_count_o = cycle_count_q;

endmodule

// File: tb/tb_pipeline_run_controller.sv
// Self-checking bench for pipeline_run_controller: directed test-plan steps
// followed by randomized run/step/abort transactions against a
// transaction-level expectation of enabled cycles, halt PC and cycle count.
module tb_pipeline_run_controller;

    localparam int unsigned DRAIN = 4;
    localparam logic [1:0]  C_RUN   = 2'b01;
    localparam logic [1:0]  C_STEP  = 2'b10;
    localparam logic [1:0]  C_ABORT = 2'b11;
    localparam logic [31:0] HALT    = 32'hFFFF_FFFF;

    logic        clock;
    logic        reset;
    logic [31:0] instr;
    logic [6:0]  pc;

    logic        en_o, run_o, sd_o, hlt_o;
    logic [6:0]  hpc_o;
    logic [31:0] cnt_o;

    logic        en2_o, run2_o, sd2_o, hlt2_o;
    logic [6:0]  hpc2_o;
    logic [3:0]  cnt2_o;

    int checks   = 0;
    int failures = 0;
    int en_cnt;
    int sd_cnt;
    longint exp_count;

    pipeline_run_controller_if cmd_if ();
    pipeline_run_controller_if cmd2_if ();

    pipeline_run_controller #(.DRAIN_CYCLES(DRAIN)) dut (
        .clock              (clock),
        .reset              (reset),
        .cmd_if             (cmd_if),
        .instruction_fetch_i(instr),
        .pc_fetch_i         (pc),
        .en_pipeline_o      (en_o),
        .running_o          (run_o),
        .step_done_o        (sd_o),
        .halted_o           (hlt_o),
        .halt_pc_o          (hpc_o),
        .cycle_count_o      (cnt_o)
    );

    pipeline_run_controller #(.NB_CYCLES(4), .DRAIN_CYCLES(DRAIN)) dut_sat (
        .clock              (clock),
        .reset              (reset),
        .cmd_if             (cmd2_if),
        .instruction_fetch_i(32'h0),
        .pc_fetch_i         (7'h0),
        .en_pipeline_o      (en2_o),
        .running_o          (run2_o),
        .step_done_o        (sd2_o),
        .halted_o           (hlt2_o),
        .halt_pc_o          (hpc2_o),
        .cycle_count_o      (cnt2_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and tally the enable/step_done level of the new cycle.
    task automatic cycle();
        @(posedge clock);
        #1;
        if (en_o) en_cnt++;
        if (sd_o) sd_cnt++;
    endtask

    task automatic send(input logic [1:0] c);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd       = c;
        cycle();
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd       = 2'b00;
    endtask

    function automatic logic [31:0] rnd_instr();
        return $urandom() & 32'hFFFF_FFFE;
    endfunction

    // Wait for DONE while offering aborts that must be refused during drain.
    task automatic wait_halt(input string tag);
        int b = 0;
        while (!hlt_o && b < 40) begin
            cmd_if.cmd_valid = 1'($urandom_range(0, 1));
            cmd_if.cmd       = C_ABORT;
            cycle();
            b++;
        end
        cmd_if.cmd_valid = 1'b0;
        chk({tag, "_halt_seen"}, 64'(hlt_o), 64'(1));
    endtask

    task automatic check_done(input string tag, input int exp_en, input logic [6:0] exp_pc);
        chk({tag, "_en_cycles"}, 64'(en_cnt), 64'(exp_en));
        chk({tag, "_halted"}, 64'(hlt_o), 64'(1));
        chk({tag, "_halt_pc"}, 64'(hpc_o), 64'(exp_pc));
        chk({tag, "_count"}, 64'(cnt_o), 64'(exp_count));
        chk({tag, "_running"}, 64'(run_o), 64'(0));
        chk({tag, "_ready"}, 64'(cmd_if.cmd_ready), 64'(1));
    endtask

    // Run with HALT fetched after nb enabled cycles.
    task automatic do_run_halt(input string tag, input int nb, input logic [6:0] hpc, input bit rnd_cmds);
        en_cnt = 0;
        instr  = rnd_instr();
        send(C_RUN);
        for (int i = 0; i < nb; i++) begin
            if (rnd_cmds) begin
                cmd_if.cmd_valid = 1'($urandom_range(0, 1));
                cmd_if.cmd       = ($urandom_range(0, 1) != 0) ? C_RUN : C_STEP;
            end
            instr = rnd_instr();
            cycle();
        end
        instr = HALT;
        pc    = hpc;
        if (rnd_cmds) begin
            cmd_if.cmd_valid = 1'($urandom_range(0, 1));
            cmd_if.cmd       = C_ABORT;
        end
        cycle();
        cmd_if.cmd_valid = 1'b0;
        instr = rnd_instr();
        pc    = 7'($urandom());
        wait_halt(tag);
        exp_count += longint'(nb + 1 + DRAIN);
        check_done(tag, nb + 1 + DRAIN, hpc);
    endtask

    task automatic do_abort_done(input string tag);
        send(C_ABORT);
        exp_count = 0;
        chk({tag, "_halted"}, 64'(hlt_o), 64'(0));
        chk({tag, "_halt_pc"}, 64'(hpc_o), 64'(0));
        chk({tag, "_count"}, 64'(cnt_o), 64'(0));
        chk({tag, "_en"}, 64'(en_o), 64'(0));
    endtask

    task automatic do_run_abort(input string tag, input int n);
        en_cnt = 0;
        instr  = rnd_instr();
        send(C_RUN);
        for (int i = 0; i < n - 1; i++) begin
            cmd_if.cmd_valid = 1'($urandom_range(0, 1));
            cmd_if.cmd       = ($urandom_range(0, 1) != 0) ? C_RUN : C_STEP;
            instr = rnd_instr();
            cycle();
        end
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd       = C_ABORT;
        cycle();
        cmd_if.cmd_valid = 1'b0;
        exp_count += longint'(n);
        chk({tag, "_en"}, 64'(en_o), 64'(0));
        chk({tag, "_en_cycles"}, 64'(en_cnt), 64'(n));
        chk({tag, "_count"}, 64'(cnt_o), 64'(exp_count));
        chk({tag, "_halted"}, 64'(hlt_o), 64'(0));
    endtask

    task automatic do_step(input string tag, input bit with_halt, input logic [6:0] hpc);
        en_cnt = 0;
        sd_cnt = 0;
        if (with_halt) begin
            instr = HALT;
            pc    = hpc;
        end else begin
            instr = rnd_instr();
        end
        send(C_STEP);
        cycle();
        instr = rnd_instr();
        if (with_halt) begin
            wait_halt(tag);
            exp_count += longint'(1 + DRAIN);
            check_done(tag, 1 + DRAIN, hpc);
            chk({tag, "_no_step_done"}, 64'(sd_cnt), 64'(0));
        end else begin
            cycle();
            exp_count += 1;
            chk({tag, "_en_cycles"}, 64'(en_cnt), 64'(1));
            chk({tag, "_step_done"}, 64'(sd_cnt), 64'(1));
            chk({tag, "_count"}, 64'(cnt_o), 64'(exp_count));
        end
    endtask

    initial begin
        reset             = 1'b1;
        instr             = 32'h0;
        pc                = 7'h0;
        cmd_if.cmd_valid  = 1'b0;
        cmd_if.cmd        = 2'b00;
        cmd2_if.cmd_valid = 1'b0;
        cmd2_if.cmd       = 2'b00;
        en_cnt            = 0;
        sd_cnt            = 0;
        exp_count         = 0;
        cycle();
        cycle();
        reset = 1'b0;

        // Reset state
        chk("rst_en", 64'(en_o), 64'(0));
        chk("rst_running", 64'(run_o), 64'(0));
        chk("rst_step_done", 64'(sd_o), 64'(0));
        chk("rst_halted", 64'(hlt_o), 64'(0));
        chk("rst_halt_pc", 64'(hpc_o), 64'(0));
        chk("rst_count", 64'(cnt_o), 64'(0));
        chk("rst_ready", 64'(cmd_if.cmd_ready), 64'(1));

        // Run with HALT at the 6th enabled cycle, pc 5
        do_run_halt("run_halt", 5, 7'd5, 1'b0);

        // Run in DONE is ignored, then abort clears
        en_cnt = 0;
        send(C_RUN);
        cycle();
        cycle();
        chk("done_run_en_cycles", 64'(en_cnt), 64'(0));
        chk("done_run_halted", 64'(hlt_o), 64'(1));
        do_abort_done("done_abort");

        // Three steps, three cycles apart
        en_cnt = 0;
        sd_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            instr = rnd_instr();
            send(C_STEP);
            cycle();
            cycle();
        end
        exp_count = 3;
        chk("steps_en_pulses", 64'(en_cnt), 64'(3));
        chk("steps_done_pulses", 64'(sd_cnt), 64'(3));
        chk("steps_count", 64'(cnt_o), 64'(3));
        chk("steps_running", 64'(run_o), 64'(0));
        chk("steps_ready", 64'(cmd_if.cmd_ready), 64'(1));

        // Step that fetches HALT at pc 2
        do_step("step_halt", 1'b1, 7'd2);
        do_abort_done("step_halt_abort");

        // Run, abort after 7 enabled cycles, then a second run keeps counting
        do_run_abort("run_abort", 7);
        do_run_abort("run_abort2", 3);
        send(C_ABORT);
        exp_count = 0;
        chk("idle_abort_count", 64'(cnt_o), 64'(0));

        // Reset during the second drain cycle
        instr = HALT;
        pc    = 7'd9;
        send(C_RUN);
        cycle();
        instr = rnd_instr();
        cycle();
        chk("drain2_en", 64'(en_o), 64'(1));
        chk("drain2_running", 64'(run_o), 64'(1));
        chk("drain2_ready", 64'(cmd_if.cmd_ready), 64'(0));
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("drain_rst_en", 64'(en_o), 64'(0));
        chk("drain_rst_running", 64'(run_o), 64'(0));
        chk("drain_rst_halted", 64'(hlt_o), 64'(0));
        chk("drain_rst_halt_pc", 64'(hpc_o), 64'(0));
        chk("drain_rst_count", 64'(cnt_o), 64'(0));
        chk("drain_rst_ready", 64'(cmd_if.cmd_ready), 64'(1));
        exp_count = 0;

        // Randomized transactions
        for (int it = 0; it < 16; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    do_run_halt("rnd_run_halt", int'($urandom_range(0, 10)), 7'($urandom()), 1'b1);
                    do_abort_done("rnd_abort_done");
                end
                1: do_run_abort("rnd_run_abort", int'($urandom_range(1, 10)));
                2: begin
                    do_step("rnd_step_halt", 1'b1, 7'($urandom()));
                    do_abort_done("rnd_step_abort");
                end
                default: do_step("rnd_step", 1'b0, 7'd0);
            endcase
        end

        // Saturation on a 4-bit counter build
        cmd2_if.cmd_valid = 1'b1;
        cmd2_if.cmd       = C_RUN;
        cycle();
        cmd2_if.cmd_valid = 1'b0;
        repeat (14) cycle();
        chk("sat_count14", 64'(cnt2_o), 64'(14));
        repeat (6) cycle();
        chk("sat_count_hold", 64'(cnt2_o), 64'(15));
        chk("sat_en", 64'(en2_o), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
